mac8_feeder: RTL and testbench
==============================

# mac8_feeder

Upstream load-and-sequence stage for the 8-lane systolic MAC array. It accepts one 8×8 matrix A and one 8-element vector B over a valid/ready word stream and buffers them locally. On a start pulse it drives the array's B stream, enable and clear inputs, and the eight parallel A inputs. Each lane's A operand is skewed so it meets the matching B element as B ripples down the array's one-stage-per-lane pipeline.

## Interface
- DATA_WIDTH, default 8: width of every A/B element.
- LANES, fixed at 8 (package constant): number of lanes, equal to the B vector length and the A row/column count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low. Reset clk.
- in_valid  in  1  load word valid.
- in_ready  out  1  load word accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  load word.
- start  in  1  single-cycle run request.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; all lane results are final.
- b_out  out  DATA_WIDTH  array B stream input.
- en_out  out  1  array enable input.
- clr_out  out  1  array clear input.
- a_out[0:7]  out  DATA_WIDTH each  array parallel A inputs.

## Operation
- States: LOAD, READY, RUN.
- LOAD:
  - in_ready=1; a 7-bit word counter w counts accepted words.
  - Words 0–7 are B[0..7].
  - Words 8–71 are A row-major: word 8+8i+k = A[i][k]. Row i is written into the lane-i buffer at slot k.
  - Accepting word 71 moves the FSM to READY and clears w to 0.
- READY:
  - in_ready=0.
  - start=1 moves the FSM to RUN and clears the phase counter p to 0.
- RUN, with p counting 0..17:
  - p=0: clr_out=1, en_out=0.
  - p=1..8: en_out=1, b_out=B[p-1].
  - p=9..17: en_out=0 (drain).
  - a_out[i] = A[i][p-i-2] when 0 ≤ p-i-2 ≤ 7.
  - p=17: done=1. The next state is LOAD with w=0.
  - A and B buffers retain their contents. A new load fully overwrites them.
- Behaviour at the edges:
  - start outside READY is ignored.
  - start in the same cycle as word 71 is ignored, because the FSM is still in LOAD.
  - in_valid outside LOAD is ignored (in_ready=0).
  - busy is high for all of RUN (p=0..17).
- Reset values, asserted at any time including mid-RUN:
  - State LOAD, w=0, p=0.
  - in_ready=1 once rst_n is released.
  - busy=0, done=0, en_out=0, clr_out=0, b_out=0, every a_out=0, all buffers 0.
  - A run interrupted by reset is abandoned and does not complete.

## Timing
- All outputs are driven directly from registers; there is no combinational path from any input to any output.
- Load takes 72 accepted transfers minimum; back-to-back transfers are one per cycle.
- The array adds one stage per lane, so lane i sees:
  - clr at p=i+1;
  - en with B[k] at p=k+i+2;
  - A[i][k] on a_out[i] in that same cycle p=k+i+2.
- Lane 7's last accumulate is at p=16 and is registered at the end of p=16. done is raised at p=17.
- start→done latency: 18 cycles. start→next in_ready: 19 cycles.

## Configuration
- MAC8_FEEDER_ZERO_GATE_EN:
  - Defined: b_out and each a_out are forced to 0 in every cycle outside that signal's valid window, i.e. b_out outside p=1..8 and a_out[i] outside p=i+2..i+9.
  - Undefined: those outputs hold their last driven value. After reset they read 0 until first driven. This lowers toggle activity.
  - en_out, clr_out, done and busy behave identically either way.

## Structure
- Shared package mac8_pkg holds:
  - localparam LANES=8;
  - LOAD_WORDS=72;
  - RUN_CYCLES=18;
  - the state enum typedef (LOAD, READY, RUN).
- Sub-module mac8_lane_buf, instantiated once per lane:
  - 8-entry DATA_WIDTH register file;
  - write port (slot, data, we);
  - registered read of slot p-LANE-2, with the lane index as a parameter;
  - an in-window flag.

## Test plan
- Reset, then stream 72 words with A[i][k]=i+1 and B[k]=1, then start → done at start+18. At p=2+i+k, a_out[i]=i+1 and b_out at p=k+1 is 1. Lane i accumulates 8·(i+1).
- Identity A (A[i][i]=1, others 0) and B={1..8} → a_out[i] is nonzero only at p=2i+2 with value 1, coinciding with lane i seeing B[i]=i+1.
- Throttled load: in_valid toggles every other cycle → exactly 72 acceptances; READY is reached only after word 71. start pulsed during LOAD and on the word-71 cycle → no RUN.
- Assert rst_n low at p=5 of a run → all outputs 0 immediately, in_ready=1 after release, no done. A reload followed by a rerun produces correct results.
- Back-to-back runs with distinct data (second run B={8..1}) → the second run's clr_out at its p=0, no carry-over, done pulses exactly once per run.
- With and without MAC8_FEEDER_ZERO_GATE_EN → check b_out at p=9 (0 vs B[7]=8) and a_out[0] at p=10 (0 vs A[0][7]); en_out and clr_out traces identical in both builds.

Source files
------------

// File: rtl/mac8_pkg.sv
// Shared constants and FSM state type for the MAC8 feeder block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac8_pkg;
    localparam int LANES      = 8;
    localparam int LOAD_WORDS = 72;   // 8 B words followed by 64 A words
    localparam int RUN_CYCLES = 18;   // phase counter p runs 0..17

    typedef enum logic [1:0] {
        LOAD,
        READY,
        RUN
    } state_t;
endpackage

// File: rtl/mac8_feeder_if.sv
// Load stream, run control and array-side outputs of the MAC8 feeder.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the load stream; array side has none.
// master: load/control source (drives in_valid, in_data, start)
// slave : mac8_feeder (drives in_ready, busy, done, b_out, en_out, clr_out, a_out)
interface mac8_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    import mac8_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] b_out;
    logic                  en_out;
    logic                  clr_out;
    logic [DATA_WIDTH-1:0] a_out [LANES];

    modport master (
        output in_valid, in_data, start,
        input  in_ready, busy, done, b_out, en_out, clr_out, a_out
    );

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, busy, done, b_out, en_out, clr_out, a_out
    );
endinterface

// File: rtl/mac8_lane_buf.sv
// Per-lane 8-entry operand buffer with a skewed, registered read port.
// Latency: read data is registered; it reflects the phase presented on p_nxt.
// Backpressure: none; writes land whenever we is high.
// Ports: clk, rst_n; write port (we, wslot, wdata); run_nxt/p_nxt give the
// phase the next cycle will be in; rd_dat = buf[p - LANE - 2] inside the window.
// MAC8_FEEDER_ZERO_GATE_EN: when defined, rd_dat is forced to 0 outside the
// window; otherwise it holds its last driven value.
module mac8_lane_buf
    import mac8_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANE       = 0    // -1 turns this into the B stream buffer (window p=1..8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [2:0]            wslot,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  run_nxt,
    input  logic [4:0]            p_nxt,
    output logic [DATA_WIDTH-1:0] rd_dat
);
    logic [DATA_WIDTH-1:0] mem [LANES];
    int                    idx;
    logic                  in_win;
    logic [2:0]            rslot;

    always_comb begin
        idx    = int'(p_nxt) - LANE - 2;
        in_win = run_nxt && (idx >= 0) && (idx < LANES);
        rslot  = idx[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < LANES; j++) mem[j] <= '0;
            rd_dat <= '0;
        end else begin
            if (we) mem[wslot] <= wdata;
            if (in_win) rd_dat <= mem[rslot];
`ifdef MAC8_FEEDER_ZERO_GATE_EN
            else        rd_dat <= '0;
`endif
        end
    end
endmodule

// File: rtl/mac8_feeder.sv
// Buffers an 8x8 A matrix and 8-element B vector, then sequences them into the systolic MAC array.
// Latency: start->done 18 cycles, start->next in_ready 19 cycles; every output is a register.
// Backpressure: in_ready is high only in LOAD; start is ignored outside READY.
// Ports: clk, rst_n (async, active-low); bus (mac8_feeder_if.slave) carrying
// the load stream, start/busy/done and the array-side b_out/en_out/clr_out/a_out.
// MAC8_FEEDER_ZERO_GATE_EN: zero b_out/a_out outside their valid windows.
module mac8_feeder
    import mac8_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mac8_feeder_if.slave  bus
);
    state_t           state, state_nxt;
    logic [6:0]       w, w_nxt;
    logic [4:0]       p, p_nxt;
    logic             accept;
    logic             run_nxt;
    logic             b_sel;
    logic [2:0]       row;
    logic [LANES-1:0] a_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            w     <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            w     <= w_nxt;
            p     <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        w_nxt     = w;
        p_nxt     = p;
        accept    = 1'b0;
        case (state)
            LOAD: begin
                accept = bus.in_valid && bus.in_ready;
                if (accept) begin
                    if (w == 7'(LOAD_WORDS - 1)) begin
                        state_nxt = READY;
                        w_nxt     = '0;
                    end else begin
                        w_nxt = w + 7'd1;
                    end
                end
            end
            READY: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    p_nxt     = '0;
                end
            end
            RUN: begin
                if (p == 5'(RUN_CYCLES - 1)) begin
                    state_nxt = LOAD;
                    w_nxt     = '0;
                    p_nxt     = '0;
                end else begin
                    p_nxt = p + 5'd1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Word w>=8 is A[(w-8)/8][w%8]; (w-8)/8 mod 8 equals w[5:3]-1 for 8..71.
    assign b_sel   = (w < 7'd8);
    assign row     = w[5:3] - 3'd1;
    assign run_nxt = (state_nxt == RUN);

    // Control outputs are registered from next-state so they line up with p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.en_out   <= 1'b0;
            bus.clr_out  <= 1'b0;
        end else begin
            bus.in_ready <= (state_nxt == LOAD);
            bus.busy     <= run_nxt;
            bus.done     <= run_nxt && (p_nxt == 5'(RUN_CYCLES - 1));
            bus.en_out   <= run_nxt && (p_nxt >= 5'd1) && (p_nxt <= 5'd8);
            bus.clr_out  <= run_nxt && (p_nxt == 5'd0);
        end
    end

    mac8_lane_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE       (-1)
    ) u_b_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept && b_sel),
        .wslot   (w[2:0]),
        .wdata   (bus.in_data),
        .run_nxt (run_nxt),
        .p_nxt   (p_nxt),
        .rd_dat  (bus.b_out)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign a_we[i] = accept && !b_sel && (row == 3'(i));

        mac8_lane_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .LANE       (i)
        ) u_a_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (a_we[i]),
            .wslot   (w[2:0]),
            .wdata   (bus.in_data),
            .run_nxt (run_nxt),
            .p_nxt   (p_nxt),
            .rd_dat  (bus.a_out[i])
        );
    end
endmodule

// File: tb/tb_mac8_feeder.sv
// Directed self-checking bench for mac8_feeder.
// Latency: n/a.
// Backpressure: exercises throttled load and ignored start/in_valid.
module tb_mac8_feeder;
    localparam int DW = 8;
`ifdef MAC8_FEEDER_ZERO_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac8_feeder_if #(.DATA_WIDTH(DW)) bus ();

    mac8_feeder #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int ma [8][8];
    int mb [8];
    int b_hold;
    int a_hold [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_holds();
        b_hold = 0;
        for (int i = 0; i < 8; i++) a_hold[i] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_en"}, bus.en_out, 0);
        check({tag, "_clr"}, bus.clr_out, 0);
        check({tag, "_b"}, bus.b_out, 0);
        for (int i = 0; i < 8; i++) check($sformatf("%s_a%0d", tag, i), bus.a_out[i], 0);
    endtask

    task automatic set_uniform();
        for (int i = 0; i < 8; i++) begin
            mb[i] = 1;
            for (int k = 0; k < 8; k++) ma[i][k] = i + 1;
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 8; i++) begin
            mb[i] = i + 1;
            for (int k = 0; k < 8; k++) ma[i][k] = (i == k) ? 1 : 0;
        end
    endtask

    task automatic set_mixed();
        for (int i = 0; i < 8; i++) begin
            mb[i] = 8 - i;
            for (int k = 0; k < 8; k++) ma[i][k] = ((8 * i + k) % 13) + 2;
        end
    endtask

    // Streams B then A row-major; optionally pokes start during the load.
    task automatic load_words(input string tag, input bit throttle, input bit poke_start);
        int   n = 0;
        int   cyc = 0;
        int   word;
        logic v;
        while (n < 72 && cyc < 400) begin
            v = throttle ? (cyc % 2 == 0) : 1'b1;
            word = (n < 8) ? mb[n] : ma[(n - 8) / 8][(n - 8) % 8];
            bus.in_valid = v;
            bus.in_data  = 8'(word);
            bus.start    = poke_start && v && (n == 10 || n == 71);
            if (v && bus.in_ready) n++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, "_accepted"}, n, 72);
        check({tag, "_ready_low"}, bus.in_ready, 0);
    endtask

    task automatic run_check(input string tag);
        int         acc [8];
        logic [7:0] bh [18];
        logic       eh [18];
        int         exp_acc;
        int         q;
        for (int i = 0; i < 8; i++) acc[i] = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 0; p < 18; p++) begin
            int eb;
            int ea;
            if (p >= 1 && p <= 8) begin
                eb = mb[p - 1];
                b_hold = eb;
            end else begin
                eb = GATED ? 0 : b_hold;
            end
            check($sformatf("%s_busy_p%0d", tag, p), bus.busy, 1);
            check($sformatf("%s_done_p%0d", tag, p), bus.done, (p == 17) ? 1 : 0);
            check($sformatf("%s_clr_p%0d", tag, p), bus.clr_out, (p == 0) ? 1 : 0);
            check($sformatf("%s_en_p%0d", tag, p), bus.en_out, (p >= 1 && p <= 8) ? 1 : 0);
            check($sformatf("%s_b_p%0d", tag, p), bus.b_out, eb);
            for (int i = 0; i < 8; i++) begin
                if (p >= i + 2 && p <= i + 9) begin
                    ea = ma[i][p - i - 2];
                    a_hold[i] = ea;
                end else begin
                    ea = GATED ? 0 : a_hold[i];
                end
                check($sformatf("%s_a%0d_p%0d", tag, i, p), bus.a_out[i], ea);
            end
            bh[p] = bus.b_out;
            eh[p] = bus.en_out;
            // Lane i sees the B stream (and its enable) i+1 cycles late.
            for (int i = 0; i < 8; i++) begin
                q = p - i - 1;
                if (q >= 0) begin
                    if (eh[q]) acc[i] += int'(bus.a_out[i]) * int'(bh[q]);
                end
            end
            tick();
        end
        check({tag, "_ready_after"}, bus.in_ready, 1);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_done_after"}, bus.done, 0);
        for (int i = 0; i < 8; i++) begin
            exp_acc = 0;
            for (int k = 0; k < 8; k++) exp_acc += ma[i][k] * mb[k];
            check($sformatf("%s_acc%0d", tag, i), acc[i], exp_acc);
        end
    endtask

    initial begin
        int dn;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.start    = 1'b0;
        clear_holds();
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_ready", bus.in_ready, 1);
        check_all_zero("rst");
        tick();
        check("rst_ready_hold", bus.in_ready, 1);

        // Uniform A rows, B all ones.
        set_uniform();
        load_words("uni", 1'b0, 1'b0);
        run_check("uni");

        // Identity A with B 1..8, throttled load and ignored start pokes.
        set_identity();
        load_words("idn", 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("idn_extra_ready%0d", c), bus.in_ready, 0);
            check($sformatf("idn_no_run%0d", c), bus.busy, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        run_check("idn");

        // Reset at p=5 abandons the run.
        set_uniform();
        load_words("abt", 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("abt_busy_p5", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        clear_holds();
        check_all_zero("abt_rst");
        tick();
        tick();
        rst_n = 1'b1;
        check("abt_ready_release", bus.in_ready, 1);
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) dn++;
            tick();
        end
        check("abt_no_done", dn, 0);
        check("abt_ready_idle", bus.in_ready, 1);
        check_all_zero("abt_idle");

        // Reload and back-to-back runs with distinct data.
        set_uniform();
        load_words("re1", 1'b0, 1'b0);
        run_check("re1");
        set_mixed();
        load_words("re2", 1'b0, 1'b0);
        run_check("re2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
